// File: rtl/ysyx_22050854_exe_stage_reg_if.sv
// ID->EXE stage bundle: decoded payload from ID, ALU status/result, MEM handshake.
// master drives the stage inputs; slave is the EXE stage register itself.
interface ysyx_22050854_exe_stage_reg_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 8
);
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_src1;
    logic [XLEN-1:0]  id_src2;
    logic [3:0]       id_ALUctr;
    logic [3:0]       id_MULctr;
    logic [2:0]       id_ALUext;
    logic [4:0]       id_rd;
    logic             id_wen;
    logic             flush;
    logic             alu_busy;
    logic [XLEN-1:0]  alu_out;
    logic             mem_allowin;

    logic             exe_allowin;
    logic             EXEreg_valid;
    logic [XLEN-1:0]  exe_pc;
    logic [XLEN-1:0]  exe_src1;
    logic [XLEN-1:0]  exe_src2;
    logic [3:0]       exe_ALUctr;
    logic [3:0]       exe_MULctr;
    logic [2:0]       exe_ALUext;
    logic [4:0]       exe_rd;
    logic             exe_wen;
    logic [XLEN-1:0]  exe_result;
    logic             exe_to_mem_valid;
    logic [CNT_W-1:0] busy_cnt;
    logic             busy_timeout;

    modport master (
        output id_valid, id_pc, id_src1, id_src2, id_ALUctr, id_MULctr, id_ALUext,
               id_rd, id_wen, flush, alu_busy, alu_out, mem_allowin,
        input  exe_allowin, EXEreg_valid, exe_pc, exe_src1, exe_src2, exe_ALUctr,
               exe_MULctr, exe_ALUext, exe_rd, exe_wen, exe_result, exe_to_mem_valid,
               busy_cnt, busy_timeout
    );

    modport slave (
        input  id_valid, id_pc, id_src1, id_src2, id_ALUctr, id_MULctr, id_ALUext,
               id_rd, id_wen, flush, alu_busy, alu_out, mem_allowin,
        output exe_allowin, EXEreg_valid, exe_pc, exe_src1, exe_src2, exe_ALUctr,
               exe_MULctr, exe_ALUext, exe_rd, exe_wen, exe_result, exe_to_mem_valid,
               busy_cnt, busy_timeout
    );
endinterface

// File: rtl/ysyx_22050854_exe_stage_reg.sv
// ID->EXE pipeline register in front of the ALU/mul/div: stalls on busy, holds results
// under MEM back-pressure, defers flushes that land mid mul/div, and runs a busy watchdog.
module ysyx_22050854_exe_stage_reg #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input logic                          clock,
    input logic                          reset,
    ysyx_22050854_exe_stage_reg_if.slave bus
);
    logic             r_valid;
    logic             r_held;
    logic             r_pend_flush;
    logic [XLEN-1:0]  r_held_val;
    logic [CNT_W-1:0] r_busy_cnt;
    logic             r_timeout;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_src1;
    logic [XLEN-1:0]  r_src2;
    logic [3:0]       r_aluctr;
    logic [3:0]       r_mulctr;
    logic [2:0]       r_aluext;
    logic [4:0]       r_rd;
    logic             r_wen;

    logic             w_ready_go;
    logic             w_allowin;
    logic             w_pend_resolve;
    logic             w_hold;
    logic             w_load;
    logic             w_timeout_hit;
    logic             w_valid_d;
    logic             w_held_d;
    logic             w_pend_flush_d;
    logic [CNT_W-1:0] w_busy_cnt_d;

    always_comb begin
        w_ready_go     = r_held | ~bus.alu_busy;
        w_allowin      = ~r_valid | (w_ready_go & bus.mem_allowin);
        // Deferred flush resolves the cycle the mul/div finishes; that result is dropped.
        w_pend_resolve = r_pend_flush & ~bus.alu_busy;
        w_hold         = r_valid & ~r_held & ~r_pend_flush & ~bus.alu_busy & ~bus.mem_allowin;
        w_load         = w_allowin & bus.id_valid;
        w_timeout_hit  = (r_busy_cnt == CNT_W'(TIMEOUT));

        w_valid_d = r_valid;
        if (w_allowin) begin
            w_valid_d = bus.id_valid & ~bus.flush;
        end else if (w_ready_go & (bus.flush | r_pend_flush)) begin
            w_valid_d = 1'b0;
        end

        w_held_d = r_held;
        if (w_allowin | bus.flush) begin
            w_held_d = 1'b0;
        end else if (w_hold) begin
            w_held_d = 1'b1;
        end

        w_pend_flush_d = r_pend_flush;
        if (w_pend_resolve) begin
            w_pend_flush_d = 1'b0;
        end else if (bus.flush & r_valid & bus.alu_busy & ~r_held) begin
            w_pend_flush_d = 1'b1;
        end

        w_busy_cnt_d = '0;
        if (r_valid & bus.alu_busy) begin
            w_busy_cnt_d = (r_busy_cnt == '1) ? r_busy_cnt : r_busy_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_held       <= 1'b0;
            r_pend_flush <= 1'b0;
            r_held_val   <= '0;
            r_busy_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_pc         <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_aluctr     <= '0;
            r_mulctr     <= '0;
            r_aluext     <= '0;
            r_rd         <= '0;
            r_wen        <= 1'b0;
        end else begin
            r_valid      <= w_valid_d;
            r_held       <= w_held_d;
            r_pend_flush <= w_pend_flush_d;
            r_busy_cnt   <= w_busy_cnt_d;
            r_timeout    <= r_timeout | w_timeout_hit;
            if (w_hold) begin
                r_held_val <= bus.alu_out;
            end
            if (w_load) begin
                r_pc     <= bus.id_pc;
                r_src1   <= bus.id_src1;
                r_src2   <= bus.id_src2;
                r_aluctr <= bus.id_ALUctr;
                r_mulctr <= bus.id_MULctr;
                r_aluext <= bus.id_ALUext;
                r_rd     <= bus.id_rd;
                r_wen    <= bus.id_wen;
            end
        end
    end

    assign bus.exe_allowin      = w_allowin;
    assign bus.EXEreg_valid     = r_valid & ~r_held & ~w_pend_resolve;
    assign bus.exe_to_mem_valid = r_valid & w_ready_go & ~r_pend_flush & ~bus.flush;
    assign bus.exe_result       = r_held ? r_held_val : bus.alu_out;
    assign bus.busy_cnt         = r_busy_cnt;
    assign bus.busy_timeout     = r_timeout | w_timeout_hit;
    assign bus.exe_pc           = r_pc;
    assign bus.exe_src1         = r_src1;
    assign bus.exe_src2         = r_src2;
    assign bus.exe_ALUctr       = r_aluctr;
    assign bus.exe_MULctr       = r_mulctr;
    assign bus.exe_ALUext       = r_aluext;
    assign bus.exe_rd           = r_rd;
    assign bus.exe_wen          = r_wen;
endmodule

// File: tb/tb_ysyx_22050854_exe_stage_reg.sv
// Bench for the EXE stage register: directed scenarios plus random traffic, all checked
// against an occupancy-slot model of the stage.
module tb_ysyx_22050854_exe_stage_reg;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 200;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_22050854_exe_stage_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) u_bus ();

    ysyx_22050854_exe_stage_reg #(
        .XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (u_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one slot holding at most one instruction, with its lifecycle flags.
    bit          m_occ, m_cap, m_doom, m_sticky;
    logic [63:0] m_val;
    int          m_cnt;
    logic [63:0] m_pc, m_s1, m_s2;
    logic [3:0]  m_actr, m_mctr;
    logic [2:0]  m_ext;
    logic [4:0]  m_rd;
    logic        m_wen;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_occ = 0; m_cap = 0; m_doom = 0; m_sticky = 0; m_val = '0; m_cnt = 0;
        m_pc = '0; m_s1 = '0; m_s2 = '0; m_actr = '0; m_mctr = '0; m_ext = '0;
        m_rd = '0; m_wen = 1'b0;
    endtask

    // Check outputs against the model for current inputs, advance the model, cross the edge.
    task automatic tick();
        bit          done, e_allow, e_aluv, e_tomem, e_tmo;
        logic [63:0] e_res;
        int          old_cnt;
        #2;
        done    = m_cap || !u_bus.alu_busy;
        e_allow = !m_occ || (done && u_bus.mem_allowin);
        e_aluv  = m_occ && !m_cap && !(m_doom && !u_bus.alu_busy);
        e_tomem = m_occ && done && !m_doom && !u_bus.flush;
        e_res   = m_cap ? m_val : u_bus.alu_out;
        e_tmo   = m_sticky || (m_cnt == int'(TIMEOUT));
        check_eq("allowin",  64'(u_bus.exe_allowin), 64'(e_allow));
        check_eq("alu_valid", 64'(u_bus.EXEreg_valid), 64'(e_aluv));
        check_eq("to_mem",   64'(u_bus.exe_to_mem_valid), 64'(e_tomem));
        check_eq("result",   u_bus.exe_result, e_res);
        check_eq("busy_cnt", 64'(u_bus.busy_cnt), 64'(m_cnt));
        check_eq("timeout",  64'(u_bus.busy_timeout), 64'(e_tmo));
        check_eq("pc",       u_bus.exe_pc, m_pc);
        check_eq("src1",     u_bus.exe_src1, m_s1);
        check_eq("src2",     u_bus.exe_src2, m_s2);
        check_eq("ctl", 64'({u_bus.exe_ALUctr, u_bus.exe_MULctr, u_bus.exe_ALUext,
                            u_bus.exe_rd, u_bus.exe_wen}),
                 64'({m_actr, m_mctr, m_ext, m_rd, m_wen}));
        if (!reset) begin
            model_clear();
        end else begin
            old_cnt = m_cnt;
            if (m_occ && u_bus.alu_busy) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            else m_cnt = 0;
            if (old_cnt == int'(TIMEOUT)) m_sticky = 1;
            if (e_allow) begin
                m_occ = u_bus.id_valid && !u_bus.flush;
                m_cap = 0; m_doom = 0;
                if (u_bus.id_valid) begin
                    m_pc = u_bus.id_pc; m_s1 = u_bus.id_src1; m_s2 = u_bus.id_src2;
                    m_actr = u_bus.id_ALUctr; m_mctr = u_bus.id_MULctr;
                    m_ext = u_bus.id_ALUext; m_rd = u_bus.id_rd; m_wen = u_bus.id_wen;
                end
            end else if (m_occ && done && (u_bus.flush || m_doom)) begin
                m_occ = 0; m_cap = 0; m_doom = 0;
            end else if (m_occ && u_bus.alu_busy && !m_cap && u_bus.flush) begin
                m_doom = 1;
            end else if (m_occ && !m_cap && !u_bus.alu_busy && !u_bus.mem_allowin) begin
                m_cap = 1; m_val = u_bus.alu_out;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [63:0] pc, input logic [63:0] s1, input logic [63:0] s2,
                        input logic [3:0] actr, input logic [3:0] mctr);
        u_bus.id_valid = 1'b1; u_bus.id_pc = pc; u_bus.id_src1 = s1; u_bus.id_src2 = s2;
        u_bus.id_ALUctr = actr; u_bus.id_MULctr = mctr; u_bus.id_ALUext = 3'd1;
        u_bus.id_rd = 5'($urandom); u_bus.id_wen = 1'b1;
        tick();
        u_bus.id_valid = 1'b0;
    endtask

    initial begin
        u_bus.id_valid = 0; u_bus.id_pc = '0; u_bus.id_src1 = '0; u_bus.id_src2 = '0;
        u_bus.id_ALUctr = '0; u_bus.id_MULctr = '0; u_bus.id_ALUext = '0; u_bus.id_rd = '0;
        u_bus.id_wen = 0; u_bus.flush = 0; u_bus.alu_busy = 0; u_bus.alu_out = '0;
        u_bus.mem_allowin = 1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        #2;
        check_eq("rst_allowin", 64'(u_bus.exe_allowin), 64'd1);
        check_eq("rst_alu_valid", 64'(u_bus.EXEreg_valid), 64'd0);
        check_eq("rst_to_mem", 64'(u_bus.exe_to_mem_valid), 64'd0);
        check_eq("rst_result", u_bus.exe_result, 64'd0);
        tick();
        reset = 1'b1;

        // Single add
        load(64'h8000_0000, 64'd5, 64'd7, 4'b0000, 4'h0);
        u_bus.alu_out = 64'd12;
        #2;
        check_eq("add_alu_valid", 64'(u_bus.EXEreg_valid), 64'd1);
        check_eq("add_to_mem", 64'(u_bus.exe_to_mem_valid), 64'd1);
        check_eq("add_result", u_bus.exe_result, 64'd12);
        check_eq("add_allowin", 64'(u_bus.exe_allowin), 64'd1);
        tick();

        // 33-cycle multiply
        load(64'h8000_0004, 64'd6, 64'd7, 4'h0, 4'h1);
        u_bus.alu_busy = 1'b1;
        for (int i = 0; i < 33; i++) begin
            #2;
            check_eq("mul_allowin", 64'(u_bus.exe_allowin), 64'd0);
            tick();
        end
        u_bus.alu_busy = 1'b0; u_bus.alu_out = 64'd42;
        #2;
        check_eq("mul_busy_cnt", 64'(u_bus.busy_cnt), 64'd33);
        check_eq("mul_to_mem", 64'(u_bus.exe_to_mem_valid), 64'd1);
        tick();
        #2;
        check_eq("mul_to_mem_once", 64'(u_bus.exe_to_mem_valid), 64'd0);

        // Hold on MEM back-pressure
        load(64'h8000_0008, 64'd3, 64'd14, 4'h0, 4'h1);
        u_bus.alu_busy = 1'b1;
        repeat (3) tick();
        u_bus.alu_busy = 1'b0; u_bus.alu_out = 64'h2A; u_bus.mem_allowin = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            u_bus.alu_out = {$urandom, $urandom};
            #2;
            check_eq("hold_alu_valid", 64'(u_bus.EXEreg_valid), 64'd0);
            check_eq("hold_result", u_bus.exe_result, 64'h2A);
            tick();
        end
        u_bus.mem_allowin = 1'b1;
        #2;
        check_eq("hold_release", 64'(u_bus.exe_to_mem_valid), 64'd1);
        check_eq("hold_release_val", u_bus.exe_result, 64'h2A);
        tick();
        #2;
        check_eq("hold_once", 64'(u_bus.exe_to_mem_valid), 64'd0);

        // Deferred flush during a divide
        load(64'h8000_000C, 64'd100, 64'd7, 4'h0, 4'h4);
        u_bus.alu_busy = 1'b1; u_bus.mem_allowin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            u_bus.flush = (i == 10);
            #2;
            check_eq("dflush_alu_valid", 64'(u_bus.EXEreg_valid), 64'd1);
            tick();
        end
        u_bus.flush = 1'b0; u_bus.alu_busy = 1'b0; u_bus.alu_out = 64'd14;
        #2;
        check_eq("dflush_drop", 64'(u_bus.exe_to_mem_valid), 64'd0);
        tick();
        #2;
        check_eq("dflush_empty", 64'(u_bus.exe_allowin), 64'd1);
        check_eq("dflush_no_valid", 64'(u_bus.EXEreg_valid), 64'd0);
        u_bus.mem_allowin = 1'b1;
        tick();

        // Flush and new load in the same cycle
        u_bus.flush = 1'b1;
        load(64'h1234, 64'd1, 64'd2, 4'h0, 4'h0);
        u_bus.flush = 1'b0;
        #2;
        check_eq("fl_ld_alu_valid", 64'(u_bus.EXEreg_valid), 64'd0);
        check_eq("fl_ld_to_mem", 64'(u_bus.exe_to_mem_valid), 64'd0);
        check_eq("fl_ld_pc", u_bus.exe_pc, 64'h1234);
        tick();

        // Watchdog
        load(64'h8000_0010, 64'd9, 64'd9, 4'h0, 4'h5);
        u_bus.alu_busy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            #2;
            if (i == int'(TIMEOUT) - 1) check_eq("wd_before", 64'(u_bus.busy_timeout), 64'd0);
            if (i == int'(TIMEOUT)) check_eq("wd_at", 64'(u_bus.busy_timeout), 64'd1);
            tick();
        end
        u_bus.alu_busy = 1'b0;
        tick();
        #2;
        check_eq("wd_sticky", 64'(u_bus.busy_timeout), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check_eq("wd_clr", 64'(u_bus.busy_timeout), 64'd0);
        check_eq("wd_clr_cnt", 64'(u_bus.busy_cnt), 64'd0);
        check_eq("wd_clr_pc", u_bus.exe_pc, 64'd0);
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 255) != 0);
            u_bus.id_valid = ($urandom_range(0, 1) == 1);
            u_bus.id_pc = {$urandom, $urandom}; u_bus.id_src1 = {$urandom, $urandom};
            u_bus.id_src2 = {$urandom, $urandom}; u_bus.id_ALUctr = 4'($urandom);
            u_bus.id_MULctr = 4'($urandom); u_bus.id_ALUext = 3'($urandom);
            u_bus.id_rd = 5'($urandom); u_bus.id_wen = 1'($urandom);
            u_bus.flush = ($urandom_range(0, 11) == 0);
            u_bus.mem_allowin = ($urandom_range(0, 3) != 0);
            if (u_bus.alu_busy) u_bus.alu_busy = ($urandom_range(0, 7) != 0);
            else u_bus.alu_busy = ($urandom_range(0, 3) == 0);
            u_bus.alu_out = {$urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050854_exe_stage_reg.md
Name: ysyx_22050854_exe_stage_reg

Overview:
ID→EXE pipeline register that sits directly upstream of the ALU/multiplier/divider. It latches decoded operands and control, and drives the ALU's valid input. It stalls while a multi-cycle mul/div is busy, and holds a finished result when MEM back-pressures, so the ALU never re-launches the same operation. It also defers flushes that arrive mid-mul/div and raises a sticky watchdog if the ALU stays busy too long.

Parameters:
XLEN, 64, operand/result width
CNT_W, 8, width of busy-cycle counter
TIMEOUT, 200, busy-cycle count at which busy_timeout is set (must be < 2^CNT_W)

Ports:
clock  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-low (0 = reset)
id_valid  in  1  ID has a valid instruction
id_pc  in  XLEN  instruction PC
id_src1, id_src2  in  XLEN  operands
id_ALUctr  in  4  ALU op select
id_MULctr  in  4  mul/div op select
id_ALUext  in  3  result-format select
id_rd  in  5  dest register; id_wen in 1 register write enable
flush  in  1  kill instruction in EXE (branch redirect)
alu_busy  in  1  ALU multi-cycle op in progress
alu_out  in  XLEN  ALU result
mem_allowin  in  1  MEM can accept this cycle
exe_allowin  out  1  EXE can accept from ID
EXEreg_valid  out  1  valid to ALU (gated, see below)
exe_pc, exe_src1, exe_src2, exe_ALUctr, exe_MULctr, exe_ALUext, exe_rd, exe_wen  out  as inputs  registered payload
exe_result  out  XLEN  result to MEM
exe_to_mem_valid  out  1  result valid for MEM
busy_cnt  out  CNT_W  consecutive busy cycles, saturating
busy_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (reset==0 at posedge): valid_r=0, held=0, pend_flush=0, busy_cnt=0, busy_timeout=0, all payload regs=0. Outputs follow: EXEreg_valid=0, exe_to_mem_valid=0, exe_allowin=1, exe_result=0.
- Ready-to-go: ready_go = held | !alu_busy.
- Allow-in: exe_allowin = !valid_r | (ready_go & mem_allowin).
- ALU valid: EXEreg_valid = valid_r & !held & !pend_flush_blocking. The ALU sees valid only until its result is captured, which prevents a mul/div relaunch.
- Result to MEM: exe_to_mem_valid = valid_r & ready_go & !pend_flush & !flush. exe_result = held ? held_val : alu_out.
- Load: when exe_allowin, valid_r <= id_valid & !flush. When exe_allowin & id_valid, latch payload. Payload is held otherwise. Latency ID→EXE is 1 cycle.
- Hold: if valid_r & !held & !alu_busy & !mem_allowin, set held_val<=alu_out and held<=1. held clears when the instruction leaves (exe_allowin).
- Flush while !alu_busy or held: valid_r<=0 next cycle, held<=0.
- Flush while alu_busy & valid_r & !held: set pend_flush=1 and keep valid_r. EXEreg_valid stays 1 so the mul/div completes; mul/div flush is tied off.
- Pending flush: when alu_busy drops, the result is discarded (exe_to_mem_valid=0), then valid_r<=0, pend_flush<=0. No further flush needed.
- Flush and new load in the same cycle: flush wins; the incoming instruction is not accepted as valid.
- busy_cnt: if valid_r & alu_busy, then busy_cnt <= busy_cnt+1, saturating at 2^CNT_W-1. Otherwise it resets to 0.
- busy_timeout: set when busy_cnt == TIMEOUT. Sticky until reset. Observation only; no effect on pipeline flow.
- Reset mid-operation: all state cleared; no deferred flush or held result survives.

Test Plan:
- Single add (ALUctr=0000, src1=5, src2=7, mem_allowin=1) → next cycle EXEreg_valid=1, exe_to_mem_valid=1, exe_result=12, exe_allowin=1.
- Mul: alu_busy=1 for 33 cycles → exe_allowin=0 throughout, busy_cnt reaches 33. On busy drop, exe_to_mem_valid=1 for exactly one cycle with mem_allowin=1.
- Hold on back-pressure: mul completes with alu_out=0x2A and mem_allowin=0 for 5 cycles → held=1, EXEreg_valid=0 (no relaunch), exe_result stays 0x2A. Raising mem_allowin gives exactly one exe_to_mem_valid pulse.
- Deferred flush: flush pulsed at busy cycle 10 of a div → EXEreg_valid stays 1 until busy drops, then exe_to_mem_valid=0 and valid_r=0 one cycle later.
- Flush and id_valid in the same cycle on a non-busy op → valid_r=0 next cycle; the ID payload is latched but never forwarded.
- Watchdog: TIMEOUT=200, alu_busy held high for 250 cycles → busy_timeout rises at count 200 and stays 1 after busy drops. reset=0 for one cycle clears it and all outputs.
